mc_control_fsm: RTL and testbench

- Multi-cycle main control unit for the RV32I core. Sequences each instruction through FETCH/DECODE/execute/writeback states.
- Produces the datapath enables and mux selects, plus the 2-bit ALUOp class that the ALU decoder consumes.
- Also keeps a retired-instruction counter used for bring-up and CPI measurement.

---
 rtl/mc_control_fsm_if.sv | 46 ++++
 rtl/mc_control_fsm.sv | 155 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle main control FSM and the RV32I datapath.
// With ILLEGAL_TRAP_EN defined the bundle also carries illegal_instr.
interface mc_control_fsm_if #(
   parameter int unsigned CNT_W = 32
) ();
   logic [6:0]       op;
   logic             zero;
   logic             PCWrite;
   logic             AdrSrc;
   logic             MemWrite;
   logic             IRWrite;
   logic [1:0]       ResultSrc;
   logic [1:0]       ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic             RegWrite;
   logic [3:0]       state;
   logic [CNT_W-1:0] instret;
`ifdef ILLEGAL_TRAP_EN
   logic             illegal_instr;

   modport master (
      input  op, zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
             RegWrite, state, instret, illegal_instr
   );

   modport slave (
      output op, zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
             RegWrite, state, instret, illegal_instr
   );
`else
   modport master (
      input  op, zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
             RegWrite, state, instret
   );

   modport slave (
      output op, zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
             RegWrite, state, instret
   );
`endif
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main control FSM (Moore) with a retired-instruction counter.
// Define ILLEGAL_TRAP_EN to park unsupported opcodes in TRAP instead of retiring them as NOPs.
module mc_control_fsm #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   mc_control_fsm_if.master bus
);
   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecuteR = 4'd6,
      StExecuteI = 4'd7,
      StAluWb    = 4'd8,
      StBeq      = 4'd9,
      StJal      = 4'd10,
      StTrap     = 4'd11
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRtype  = 7'b0110011;
   localparam logic [6:0] OpItype  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   state_e           r_state;
   state_e           w_next_state;
   logic [CNT_W-1:0] r_instret;
   logic             w_pc_update;
   logic             w_branch;
   logic             w_mem_write;
   logic             w_ir_write;
   logic             w_reg_write;
   logic             w_retire;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= StFetch;
         r_instret <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   // An instruction retires on the edge that returns to FETCH from any other state.
   assign w_retire = (w_next_state == StFetch) && (r_state != StFetch);

   always_comb begin
      w_next_state  = r_state;
      w_pc_update   = 1'b0;
      w_branch      = 1'b0;
      w_mem_write   = 1'b0;
      w_ir_write    = 1'b0;
      w_reg_write   = 1'b0;
      bus.AdrSrc    = 1'b0;
      bus.ResultSrc = 2'b00;
      bus.ALUSrcA   = 2'b00;
      bus.ALUSrcB   = 2'b00;
      bus.ALUOp     = 2'b00;
      case (r_state)
         StFetch: begin
            w_ir_write    = 1'b1;
            w_pc_update   = 1'b1;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
            w_next_state  = StDecode;
         end
         StDecode: begin
            bus.ALUSrcA = 2'b01;
            bus.ALUSrcB = 2'b01;
            case (bus.op)
               OpLoad, OpStore: w_next_state = StMemAdr;
               OpRtype:         w_next_state = StExecuteR;
               OpItype:         w_next_state = StExecuteI;
               OpBranch:        w_next_state = StBeq;
               OpJal:           w_next_state = StJal;
`ifdef ILLEGAL_TRAP_EN
               default:         w_next_state = StTrap;
`else
               default:         w_next_state = StFetch;
`endif
            endcase
         end
         StMemAdr: begin
            bus.ALUSrcA  = 2'b10;
            bus.ALUSrcB  = 2'b01;
            w_next_state = (bus.op == OpLoad) ? StMemRead : StMemWrite;
         end
         StMemRead: begin
            bus.AdrSrc   = 1'b1;
            w_next_state = StMemWb;
         end
         StMemWb: begin
            bus.ResultSrc = 2'b01;
            w_reg_write   = 1'b1;
            w_next_state  = StFetch;
         end
         StMemWrite: begin
            bus.AdrSrc   = 1'b1;
            w_mem_write  = 1'b1;
            w_next_state = StFetch;
         end
         StExecuteR: begin
            bus.ALUSrcA  = 2'b10;
            bus.ALUOp    = 2'b10;
            w_next_state = StAluWb;
         end
         StExecuteI: begin
            bus.ALUSrcA  = 2'b10;
            bus.ALUSrcB  = 2'b01;
            bus.ALUOp    = 2'b10;
            w_next_state = StAluWb;
         end
         StAluWb: begin
            w_reg_write  = 1'b1;
            w_next_state = StFetch;
         end
         StBeq: begin
            bus.ALUSrcA  = 2'b10;
            bus.ALUOp    = 2'b01;
            w_branch     = 1'b1;
            w_next_state = StFetch;
         end
         StJal: begin
            bus.ALUSrcA  = 2'b01;
            bus.ALUSrcB  = 2'b10;
            w_pc_update  = 1'b1;
            w_next_state = StAluWb;
         end
`ifdef ILLEGAL_TRAP_EN
         StTrap: w_next_state = StTrap;
`endif
         default: w_next_state = StFetch;
      endcase
   end

   assign bus.PCWrite  = ~reset & (w_pc_update | (w_branch & bus.zero));
   assign bus.MemWrite = ~reset & w_mem_write;
   assign bus.IRWrite  = ~reset & w_ir_write;
   assign bus.RegWrite = ~reset & w_reg_write;
   assign bus.state    = r_state;
   assign bus.instret  = r_instret;
`ifdef ILLEGAL_TRAP_EN
   assign bus.illegal_instr = (r_state == StTrap);
`endif
endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus pushes per-cycle expectations, monitors compare.
// Also exercises a CNT_W=4 instance for counter wrap; honours ILLEGAL_TRAP_EN.
module tb_mc_control_fsm;
   typedef struct packed {
      logic [3:0]  st;
      logic        pcw;
      logic        adr;
      logic        mw;
      logic        irw;
      logic [1:0]  rs;
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic [1:0]  aop;
      logic        rw;
      logic        ill;
      logic [31:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rst4;
   logic [6:0]  op;
   logic        zero;
   logic [31:0] exp_cnt;
   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        q[$];
   string       qn[$];
   logic [7:0]  q4[$];

   always #5 clk = ~clk;

   mc_control_fsm_if #(.CNT_W(32)) bus ();
   mc_control_fsm_if #(.CNT_W(4))  bus4 ();

   mc_control_fsm #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   mc_control_fsm #(.CNT_W(4)) dut4 (
      .clk   (clk),
      .reset (rst4),
      .bus   (bus4)
   );

   assign bus.op    = op;
   assign bus.zero  = zero;
   assign bus4.op   = 7'b1100011;
   assign bus4.zero = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Hand-written per-state output table; rst forces the four enables low.
   function automatic exp_t exp_of(input logic [3:0] s, input logic z, input logic rst,
                                   input logic [31:0] cnt);
      exp_t e;
      e     = '0;
      e.st  = s;
      e.cnt = cnt;
      case (s)
         4'd0:  begin e.irw = 1'b1; e.pcw = 1'b1; e.sb = 2'b10; e.rs = 2'b10; end
         4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
         4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
         4'd3:  e.adr = 1'b1;
         4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; end
         4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
         4'd6:  begin e.sa = 2'b10; e.aop = 2'b10; end
         4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
         4'd8:  e.rw = 1'b1;
         4'd9:  begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = z; end
         4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
         4'd11: e.ill = 1'b1;
         default: ;
      endcase
      if (rst) begin
         e.pcw = 1'b0;
         e.mw  = 1'b0;
         e.irw = 1'b0;
         e.rw  = 1'b0;
      end
      return e;
   endfunction

   task automatic expect_cycle(input string nm, input exp_t e);
      q.push_back(e);
      qn.push_back(nm);
      @(posedge clk);
      #1;
   endtask

   // seq holds the expected state of cycle i in nibble i; op is X during FETCH.
   task automatic run_instr(input string nm, input logic [6:0] opc, input logic z, input int n,
                            input logic [23:0] seq, input logic retire);
      for (int i = 0; i < n; i++) begin
         op   = (i == 0) ? 7'bxxxxxxx : opc;
         zero = z;
         expect_cycle($sformatf("%s c%0d", nm, i), exp_of(seq[4*i +: 4], z, 1'b0, exp_cnt));
      end
      if (retire) exp_cnt = exp_cnt + 1;
   endtask

   always @(negedge clk) begin
      exp_t  e;
      string nm;
      logic  ill;
      if (q.size() > 0) begin
         e  = q.pop_front();
         nm = qn.pop_front();
`ifdef ILLEGAL_TRAP_EN
         ill = bus.illegal_instr;
`else
         ill = 1'b0;
`endif
         chk({nm, " state"},     32'(bus.state),     32'(e.st));
         chk({nm, " PCWrite"},   32'(bus.PCWrite),   32'(e.pcw));
         chk({nm, " AdrSrc"},    32'(bus.AdrSrc),    32'(e.adr));
         chk({nm, " MemWrite"},  32'(bus.MemWrite),  32'(e.mw));
         chk({nm, " IRWrite"},   32'(bus.IRWrite),   32'(e.irw));
         chk({nm, " ResultSrc"}, 32'(bus.ResultSrc), 32'(e.rs));
         chk({nm, " ALUSrcA"},   32'(bus.ALUSrcA),   32'(e.sa));
         chk({nm, " ALUSrcB"},   32'(bus.ALUSrcB),   32'(e.sb));
         chk({nm, " ALUOp"},     32'(bus.ALUOp),     32'(e.aop));
         chk({nm, " RegWrite"},  32'(bus.RegWrite),  32'(e.rw));
         chk({nm, " illegal"},   32'(ill),           32'(e.ill));
         chk({nm, " instret"},   bus.instret,        e.cnt);
      end
   end

   always @(negedge clk) begin
      logic [7:0] v;
      if (q4.size() > 0) begin
         v = q4.pop_front();
         chk("cnt4 state",   32'(bus4.state),   32'(v[7:4]));
         chk("cnt4 instret", 32'(bus4.instret), 32'(v[3:0]));
      end
   end

   initial begin
      reset   = 1'b1;
      rst4    = 1'b1;
      op      = 7'd0;
      zero    = 1'b0;
      exp_cnt = 32'd0;
      @(posedge clk);
      #1;
      expect_cycle("reset", exp_of(4'd0, 1'b0, 1'b1, 32'd0));
      reset = 1'b0;

      run_instr("lw",      7'b0000011, 1'b0, 5, 24'h043210, 1'b1);
      run_instr("sw",      7'b0100011, 1'b0, 4, 24'h005210, 1'b1);
      run_instr("rtype",   7'b0110011, 1'b0, 4, 24'h008610, 1'b1);
      run_instr("itype",   7'b0010011, 1'b0, 4, 24'h008710, 1'b1);
      run_instr("beq_z1",  7'b1100011, 1'b1, 3, 24'h000910, 1'b1);
      run_instr("beq_z0",  7'b1100011, 1'b0, 3, 24'h000910, 1'b1);
      run_instr("jal",     7'b1101111, 1'b0, 4, 24'h008a10, 1'b1);

      // Reset while in MEMREAD: instruction abandoned, no writeback, no count.
      run_instr("lw_abort", 7'b0000011, 1'b0, 3, 24'h000210, 1'b0);
      reset = 1'b1;
      expect_cycle("rst_memread", exp_of(4'd3, 1'b0, 1'b1, exp_cnt));
      reset   = 1'b0;
      exp_cnt = 32'd0;
      run_instr("lw_after", 7'b0000011, 1'b0, 5, 24'h043210, 1'b1);

`ifdef ILLEGAL_TRAP_EN
      run_instr("ecall", 7'b1110011, 1'b0, 2, 24'h000010, 1'b0);
      for (int i = 0; i < 10; i++) begin
         expect_cycle($sformatf("trap c%0d", i), exp_of(4'd11, 1'b0, 1'b0, exp_cnt));
      end
      reset = 1'b1;
      expect_cycle("trap_reset", exp_of(4'd11, 1'b0, 1'b1, exp_cnt));
      reset   = 1'b0;
      exp_cnt = 32'd0;
`else
      run_instr("ecall", 7'b1110011, 1'b0, 2, 24'h000010, 1'b1);
`endif
      run_instr("beq_last", 7'b1100011, 1'b1, 3, 24'h000910, 1'b1);
      expect_cycle("final_fetch", exp_of(4'd0, 1'b0, 1'b0, exp_cnt));

      // Narrow counter: 17 beq retirements wrap a 4-bit instret to 1.
      reset = 1'b1;
      rst4  = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         repeat (3) begin
            @(posedge clk);
            #1;
         end
         if (k == 15) q4.push_back({4'd0, 4'd15});
         if (k == 16) q4.push_back({4'd0, 4'd0});
         if (k == 17) q4.push_back({4'd0, 4'd1});
      end
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (q.size() != 0 || q4.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size() + q4.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
